// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared decode constants, scoreboard entry type and helpers
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic [4:0] dest;
      logic       is_load;
      logic [4:0] rs;
      logic [4:0] rt;
   } sb_entry_t;

   typedef enum logic {
      ST_RUN,
      ST_LU_STALL
   } hz_state_e;

   // Entry writes a non-zero register equal to r.
   function automatic logic src_hit(
      sb_entry_t  e,
      logic [4:0] r
   );
      return e.valid && e.wr &&
             (e.dest == r) && (r != 5'd0);
   endfunction

   // A load in MEM has no result yet, so it
   // cannot feed EX from the EX/MEM register.
   function automatic logic [1:0] fwd_sel(
      sb_entry_t  mem,
      sb_entry_t  wb,
      logic [4:0] src
   );
      if (src_hit(mem, src) && !mem.is_load)
         return FWD_EXMEM;
      else if (src_hit(wb, src))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of an instruction into its hazard view.
// in: inst; out: dest, wr, is_load, uses_rs, uses_rt.
module hazard_decode
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output logic [4:0]  dest,
   output logic        wr,
   output logic        is_load,
   output logic        uses_rs,
   output logic        uses_rt
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_shamt;

   assign op           = inst[31:26];
   assign fn           = inst[5:0];
   assign unused_shamt = ^inst[10:6];

   always_comb begin
      dest    = 5'd0;
      is_load = 1'b0;
      uses_rs = 1'b1;
      uses_rt = 1'b0;
      unique case (op)
         OP_SPECIAL: begin
            dest    = inst[15:11];
            uses_rt = 1'b1;
            // Shifts take their operand from rt only.
            uses_rs = !(fn == FN_SLL ||
                        fn == FN_SRL ||
                        fn == FN_SRA);
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            dest = inst[20:16];
         end
         OP_LW: begin
            dest    = inst[20:16];
            is_load = 1'b1;
         end
         OP_SW, OP_BEQ: begin
            uses_rt = 1'b1;
         end
         default: ;
      endcase
      wr = (dest != 5'd0);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: EX/MEM/WB dest scoreboard driving load-use
// stalls, branch flushes, EX forwarding selects and perf counters.
// in: clock, reset, id_inst, id_valid, branch_taken, ext_stall
// out: stall_pc/ifid, bubble_idex, flush_ifid/exmem,
//      fwd_a/b_sel, stall_count, flush_count
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter bit ENABLE_FWD = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      id_inst,
   input  logic             id_valid,
   input  logic             branch_taken,
   input  logic             ext_stall,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             flush_exmem,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [4:0] id_dest;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_wr;
   logic       id_ld;
   logic       id_urs;
   logic       id_urt;

   assign id_rs = id_inst[25:21];
   assign id_rt = id_inst[20:16];

   hazard_decode u_dec (
      .inst    (id_inst),
      .dest    (id_dest),
      .wr      (id_wr),
      .is_load (id_ld),
      .uses_rs (id_urs),
      .uses_rt (id_urt)
   );

   sb_entry_t  ex_q, ex_d;
   sb_entry_t  mem_q, mem_d;
   sb_entry_t  wb_q, wb_d;
   hz_state_e  state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic ex_src;
   logic mem_src;
   logic lu_hit;
   logic raw_hit;
   logic flush;
   logic stall;

   always_comb begin
      ex_src  = (id_urs && src_hit(ex_q, id_rs)) ||
                (id_urt && src_hit(ex_q, id_rt));
      mem_src = (id_urs && src_hit(mem_q, id_rs)) ||
                (id_urt && src_hit(mem_q, id_rt));
      lu_hit  = id_valid && ex_q.is_load && ex_src &&
                (state_q == ST_RUN);
      raw_hit = !ENABLE_FWD && id_valid &&
                (ex_src || mem_src);
      flush   = branch_taken && !ext_stall;
      stall   = (lu_hit || raw_hit) && !flush;

      stall_pc    = stall;
      stall_ifid  = stall;
      bubble_idex = stall || flush;
      flush_ifid  = flush;
      flush_exmem = flush;

      fwd_a_sel = FWD_RF;
      fwd_b_sel = FWD_RF;
      if (ENABLE_FWD && ex_q.valid) begin
         fwd_a_sel = fwd_sel(mem_q, wb_q, ex_q.rs);
         fwd_b_sel = fwd_sel(mem_q, wb_q, ex_q.rt);
      end

      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (!ext_stall) begin
         wb_d  = mem_q;
         mem_d = flush ? '0 : ex_q;
         if (flush || stall || !id_valid)
            ex_d = '0;
         else
            ex_d = '{valid:   1'b1,
                     wr:      id_wr,
                     dest:    id_dest,
                     is_load: id_ld,
                     rs:      id_rs,
                     rt:      id_rt};

         unique case (state_q)
            ST_RUN:
               if (lu_hit && stall)
                  state_d = ST_LU_STALL;
            ST_LU_STALL:
               state_d = ST_RUN;
            default:
               state_d = ST_RUN;
         endcase

         stall_cnt_d = stall_cnt_q +
                       {{(CNT_W-1){1'b0}}, stall};
         flush_cnt_d = flush_cnt_q +
                       {{(CNT_W-1){1'b0}}, flush};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases then random traffic,
// all outputs compared every cycle against an in-flight list model.
module tb_pipe_hazard_ctrl;

   localparam int CW = 6;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   id_inst;
   logic          id_valid;
   logic          branch_taken;
   logic          ext_stall;
   logic          stall_pc;
   logic          stall_ifid;
   logic          bubble_idex;
   logic          flush_ifid;
   logic          flush_exmem;
   logic [1:0]    fwd_a_sel;
   logic [1:0]    fwd_b_sel;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;

   pipe_hazard_ctrl #(.CNT_W(CW), .ENABLE_FWD(1'b1)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_inst      (id_inst),
      .id_valid     (id_valid),
      .branch_taken (branch_taken),
      .ext_stall    (ext_stall),
      .stall_pc     (stall_pc),
      .stall_ifid   (stall_ifid),
      .bubble_idex  (bubble_idex),
      .flush_ifid   (flush_ifid),
      .flush_exmem  (flush_exmem),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   always #5 clock = ~clock;

   // One in-flight instruction; dest==0 means it writes nothing.
   typedef struct {
      bit       v;
      bit [4:0] dest;
      bit       ld;
      bit [4:0] rs;
      bit [4:0] rt;
   } rec_t;

   rec_t        m_ex, m_mem, m_wb;
   bit [CW-1:0] m_sc, m_fc;
   bit          m_stall, m_flush;
   int          checks = 0;
   int          failures = 0;
   logic [1:0]  o_fa, o_fb;
   logic        o_stall, o_bub, o_fi, o_fe;

   function automatic rec_t dec(logic [31:0] i);
      rec_t r;
      bit [5:0] op;
      op   = i[31:26];
      r.v  = 1'b1;
      r.rs = i[25:21];
      r.rt = i[20:16];
      r.ld = (op == 6'h23);
      if (op == 6'h00)
         r.dest = i[15:11];
      else if (op == 6'h08 || op == 6'h0C ||
               op == 6'h0D || op == 6'h23)
         r.dest = i[20:16];
      else
         r.dest = 5'd0;
      return r;
   endfunction

   function automatic bit reads_rs(logic [31:0] i);
      bit [5:0] fn;
      fn = i[5:0];
      return !(i[31:26] == 6'h00 &&
               (fn == 6'h00 || fn == 6'h02 || fn == 6'h03));
   endfunction

   function automatic bit reads_rt(logic [31:0] i);
      return i[31:26] == 6'h00 || i[31:26] == 6'h2B ||
             i[31:26] == 6'h04;
   endfunction

   function automatic bit [1:0] fsel(bit [4:0] s);
      if (!m_ex.v) return 2'd0;
      if (m_mem.v && m_mem.dest != 0 && !m_mem.ld &&
          m_mem.dest == s) return 2'd1;
      if (m_wb.v && m_wb.dest != 0 && m_wb.dest == s)
         return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] rr(
      int rd, int rs, int rt, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] ii(
      logic [5:0] op, int rs, int rt);
      return {op, 5'(rs), 5'(rt), 16'h0004};
   endfunction

   function automatic logic [31:0] rnd_inst();
      int a, b, c;
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
         0: return rr(a, b, c, 6'h20);
         1: return rr(a, b, c, 6'h00);
         2: return ii(6'h23, b, a);
         3: return ii(6'h2B, b, a);
         4: return ii(6'h04, b, a);
         5: return ii(6'h08, b, a);
         6: return ii(6'h0D, b, a);
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // One clock: predict and compare at negedge, advance model at posedge.
   task automatic cyc();
      rec_t d;
      bit   lu;
      @(negedge clock);
      d  = dec(id_inst);
      lu = id_valid && m_ex.v && m_ex.ld && m_ex.dest != 0 &&
           ((reads_rs(id_inst) && d.rs == m_ex.dest) ||
            (reads_rt(id_inst) && d.rt == m_ex.dest));
      m_flush = branch_taken && !ext_stall;
      m_stall = lu && !m_flush;
      o_stall = stall_pc;
      o_bub   = bubble_idex;
      o_fi    = flush_ifid;
      o_fe    = flush_exmem;
      o_fa    = fwd_a_sel;
      o_fb    = fwd_b_sel;
      if (!reset) begin
         chk("stall_pc", stall_pc, m_stall);
         chk("stall_ifid", stall_ifid, m_stall);
         chk("bubble_idex", bubble_idex, m_stall || m_flush);
         chk("flush_ifid", flush_ifid, m_flush);
         chk("flush_exmem", flush_exmem, m_flush);
         chk("fwd_a_sel", fwd_a_sel, fsel(m_ex.rs));
         chk("fwd_b_sel", fwd_b_sel, fsel(m_ex.rt));
         chk("stall_count", stall_count, m_sc);
         chk("flush_count", flush_count, m_fc);
      end
      @(posedge clock);
      if (reset) begin
         m_ex  = '{default: 0};
         m_mem = '{default: 0};
         m_wb  = '{default: 0};
         m_sc  = '0;
         m_fc  = '0;
      end else if (!ext_stall) begin
         m_wb  = m_mem;
         m_mem = m_flush ? '{default: 0} : m_ex;
         if (m_flush || m_stall || !id_valid)
            m_ex = '{default: 0};
         else
            m_ex = d;
         m_sc = m_sc + CW'(m_stall);
         m_fc = m_fc + CW'(m_flush);
      end
      #1;
   endtask

   // Present an instruction until it leaves ID; counts DUT stall cycles.
   task automatic issue(logic [31:0] i, output int nst);
      id_inst  = i;
      id_valid = 1'b1;
      nst      = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (o_stall === 1'b1) nst++;
         if (!m_stall) break;
      end
   endtask

   task automatic bub();
      id_valid = 1'b0;
      id_inst  = 32'd0;
      cyc();
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      id_valid     = 1'b0;
      id_inst      = 32'd0;
      branch_taken = 1'b0;
      ext_stall    = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  hold;
      do_reset();
      bub();
      chk("rst_sc", stall_count, 0);
      chk("rst_bub", o_bub, 0);

      // load-use: one stall, then WB forward
      issue(ii(6'h23, 1, 2), n);
      issue(rr(3, 2, 4, 6'h20), n);
      chk("t1_stall_cycles", n, 1);
      bub();
      chk("t1_fwd_a", o_fa, 2);
      chk("t1_fwd_b", o_fb, 0);
      chk("t1_sc", stall_count, 1);

      // back-to-back ALU: MEM forward on both operands
      do_reset();
      issue(rr(2, 1, 1, 6'h20), n);
      issue(rr(3, 2, 2, 6'h22), n);
      chk("t2_nostall", n, 0);
      bub();
      chk("t2_fwd_a", o_fa, 1);
      chk("t2_fwd_b", o_fb, 1);

      // two apart: WB forward
      do_reset();
      issue(rr(2, 1, 1, 6'h20), n);
      issue(rr(5, 7, 8, 6'h25), n);
      issue(rr(6, 2, 2, 6'h24), n);
      bub();
      chk("t3_fwd_a", o_fa, 2);
      chk("t3_fwd_b", o_fb, 2);

      // producer writing $0 never forwards
      do_reset();
      issue(rr(0, 1, 1, 6'h20), n);
      issue(rr(6, 0, 0, 6'h24), n);
      bub();
      chk("t3_zero_a", o_fa, 0);
      chk("t3_zero_b", o_fb, 0);

      // flush beats a pending load-use stall
      do_reset();
      issue(ii(6'h23, 1, 2), n);
      id_inst      = rr(3, 2, 4, 6'h20);
      branch_taken = 1'b1;
      cyc();
      chk("t4_flush_ifid", o_fi, 1);
      chk("t4_flush_exmem", o_fe, 1);
      chk("t4_bubble", o_bub, 1);
      chk("t4_stall", o_stall, 0);
      branch_taken = 1'b0;
      chk("t4_fc", flush_count, 1);
      chk("t4_sc", stall_count, 0);

      // branch held across a 3-cycle freeze: one flush on release
      do_reset();
      issue(rr(2, 1, 1, 6'h20), n);
      id_valid     = 1'b0;
      branch_taken = 1'b1;
      ext_stall    = 1'b1;
      repeat (3) begin
         cyc();
         chk("t5_no_flush", o_fi, 0);
         chk("t5_fc_frozen", flush_count, 0);
      end
      ext_stall = 1'b0;
      cyc();
      chk("t5_release_flush", o_fi, 1);
      branch_taken = 1'b0;
      bub();
      chk("t5_fc", flush_count, 1);

      // reset in the middle of a load-use stall
      do_reset();
      issue(ii(6'h23, 1, 2), n);
      id_inst  = rr(3, 2, 4, 6'h20);
      id_valid = 1'b1;
      cyc();
      chk("t6_in_stall", o_stall, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      bub();
      chk("t6_stall", o_stall, 0);
      chk("t6_bub", o_bub, 0);
      chk("t6_flush", o_fi, 0);
      chk("t6_fwd_a", o_fa, 0);
      chk("t6_fwd_b", o_fb, 0);
      chk("t6_sc", stall_count, 0);
      chk("t6_fc", flush_count, 0);
      issue(ii(6'h23, 1, 2), n);
      issue(rr(3, 2, 4, 6'h20), n);
      chk("t6_restall", n, 1);

      // flush counter wraps modulo 2^CW
      do_reset();
      id_valid     = 1'b0;
      branch_taken = 1'b1;
      repeat (70) cyc();
      branch_taken = 1'b0;
      bub();
      chk("t7_fc_wrap", flush_count, 70 % 64);

      // random traffic against the model
      do_reset();
      hold = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         reset        = ($urandom_range(0, 499) == 0);
         ext_stall    = ($urandom_range(0, 6) == 0);
         branch_taken = ($urandom_range(0, 5) == 0);
         if (!hold) begin
            id_inst  = rnd_inst();
            id_valid = ($urandom_range(0, 9) != 0);
         end
         cyc();
         hold = m_stall || ext_stall;
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
